pkt_gen: RTL and testbench

PKT_GEN -- requirements
Module: pkt_gen

---
 rtl/pkt_gen_if.sv | 14 +
 rtl/pkt_gen.sv | 210 +++++++++++++++++++++
 tb/tb_pkt_gen.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_gen_if.sv
// Beat stream from the packet generator to its downstream sink.
// A beat transfers on a rising clock edge when wr_vld && ready.
interface pkt_gen_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  wr_sop;
   logic                  wr_eop;
   logic                  wr_vld;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  ready;

   modport master (output wr_sop, output wr_eop, output wr_vld, output wr_data, input ready);
   modport slave  (input wr_sop, input wr_eop, input wr_vld, input wr_data, output ready);
endinterface

// File: rtl/pkt_gen.sv
// Packet generator: emits runs of header + payload packets with an
// optional inter-packet gap, under ready back-pressure.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// HDR   | header beat presented
// PAY   | payload beat beat_q (1..len) presented
// GAP   | wr_vld low, gap_cnt_q cycles remain before the next header
module pkt_gen #(
   parameter int DATA_WIDTH   = 16,
   parameter int PORT_BIT     = 4,
   parameter int PRIORITY_BIT = 3,
   parameter int LEN_BIT      = 7,
   parameter int CNT_BIT      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic [LEN_BIT-1:0]      cfg_len_i,
   input  logic [7:0]              cfg_gap_i,
   input  logic [CNT_BIT-1:0]      cfg_num_i,
   input  logic [PORT_BIT-1:0]     cfg_port_i,
   input  logic                    cfg_port_inc_i,
   input  logic [PRIORITY_BIT-1:0] cfg_prio_i,
   input  logic                    cfg_mode_i,
   input  logic [DATA_WIDTH-1:0]   cfg_step_i,
   pkt_gen_if.master               wr,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [CNT_BIT-1:0]      pkt_cnt_o
);

   typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

   state_t                  state_q, state_d;
   logic [LEN_BIT-1:0]      len_q, len_d;
   logic [7:0]              gap_q, gap_d;
   logic [CNT_BIT-1:0]      num_q, num_d;
   logic [PORT_BIT-1:0]     port_q, port_d;
   logic                    port_inc_q, port_inc_d;
   logic [PRIORITY_BIT-1:0] prio_q, prio_d;
   logic                    mode_q, mode_d;
   logic [DATA_WIDTH-1:0]   step_q, step_d;
   logic [DATA_WIDTH-1:0]   pat_q, pat_d;
   logic [LEN_BIT-1:0]      beat_q, beat_d;
   logic [7:0]              gap_cnt_q, gap_cnt_d;
   logic [CNT_BIT-1:0]      pkt_cnt_q, pkt_cnt_d;
   logic                    stop_pend_q, stop_pend_d;
   logic                    sop_q, sop_d, eop_q, eop_d, vld_q, vld_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    busy_q, busy_d, done_q, done_d;

   logic                    xfer;
   logic [CNT_BIT-1:0]      cnt_inc;
   logic [DATA_WIDTH-1:0]   hdr;

   if (PORT_BIT + PRIORITY_BIT + LEN_BIT > DATA_WIDTH) begin : g_width_chk
      $error("pkt_gen: header fields do not fit in DATA_WIDTH");
   end

   assign xfer    = vld_q && wr.ready;
   assign cnt_inc = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + CNT_BIT'(1);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      gap_d       = gap_q;
      num_d       = num_q;
      port_d      = port_q;
      port_inc_d  = port_inc_q;
      prio_d      = prio_q;
      mode_d      = mode_q;
      step_d      = step_q;
      pat_d       = pat_q;
      beat_d      = beat_q;
      gap_cnt_d   = gap_cnt_q;
      pkt_cnt_d   = pkt_cnt_q;
      stop_pend_d = stop_pend_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d       = (cfg_len_i == '0) ? LEN_BIT'(1) : cfg_len_i;
               gap_d       = cfg_gap_i;
               num_d       = cfg_num_i;
               port_d      = cfg_port_i;
               port_inc_d  = cfg_port_inc_i;
               prio_d      = cfg_prio_i;
               mode_d      = cfg_mode_i;
               step_d      = cfg_step_i;
               pat_d       = cfg_mode_i ? DATA_WIDTH'(1) : '0;
               pkt_cnt_d   = '0;
               stop_pend_d = 1'b0;
               state_d     = HDR;
            end
         end
         HDR: begin
            if (stop_i) stop_pend_d = 1'b1;
            if (xfer) begin
               beat_d  = LEN_BIT'(1);
               state_d = PAY;
            end
         end
         PAY: begin
            if (stop_i) stop_pend_d = 1'b1;
            if (xfer) begin
               pat_d = mode_q ? {pat_q[DATA_WIDTH-2:0], pat_q[DATA_WIDTH-1]} : pat_q + step_q;
               if (beat_q == len_q) begin
                  pkt_cnt_d = cnt_inc;
                  if (port_inc_q) port_d = port_q + PORT_BIT'(1);
                  if (((num_q != '0) && (cnt_inc == num_q)) || stop_pend_q || stop_i) begin
                     state_d     = IDLE;
                     done_d      = 1'b1;
                     stop_pend_d = 1'b0;
                  end else if (gap_q != 8'd0) begin
                     gap_cnt_d = gap_q;
                     state_d   = GAP;
                  end else begin
                     state_d = HDR;
                  end
               end else begin
                  beat_d = beat_q + LEN_BIT'(1);
               end
            end
         end
         GAP: begin
            // a stop seen while idling between packets ends the run without another header
            if (stop_i || stop_pend_q) begin
               state_d     = IDLE;
               done_d      = 1'b1;
               stop_pend_d = 1'b0;
            end else if (gap_cnt_q == 8'd1) begin
               state_d = HDR;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      hdr = '0;
      hdr[PORT_BIT-1:0]                            = port_d;
      hdr[PORT_BIT +: PRIORITY_BIT]                = prio_d;
      hdr[PORT_BIT+PRIORITY_BIT +: LEN_BIT]        = len_d;

      // outputs are the registered image of the next state, so a stall keeps them frozen
      busy_d = (state_d != IDLE);
      vld_d  = (state_d == HDR) || (state_d == PAY);
      sop_d  = (state_d == HDR);
      eop_d  = (state_d == PAY) && (beat_d == len_d);
      data_d = (state_d == HDR) ? hdr : ((state_d == PAY) ? pat_d : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         gap_q       <= '0;
         num_q       <= '0;
         port_q      <= '0;
         port_inc_q  <= 1'b0;
         prio_q      <= '0;
         mode_q      <= 1'b0;
         step_q      <= '0;
         pat_q       <= '0;
         beat_q      <= '0;
         gap_cnt_q   <= '0;
         pkt_cnt_q   <= '0;
         stop_pend_q <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         vld_q       <= 1'b0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         gap_q       <= gap_d;
         num_q       <= num_d;
         port_q      <= port_d;
         port_inc_q  <= port_inc_d;
         prio_q      <= prio_d;
         mode_q      <= mode_d;
         step_q      <= step_d;
         pat_q       <= pat_d;
         beat_q      <= beat_d;
         gap_cnt_q   <= gap_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
         stop_pend_q <= stop_pend_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         vld_q       <= vld_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign wr.wr_sop  = sop_q;
   assign wr.wr_eop  = eop_q;
   assign wr.wr_vld  = vld_q;
   assign wr.wr_data = data_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_gen.sv
// Directed bench for pkt_gen: a table of whole-run configurations with
// hand-computed results, plus sequences for stall, stop and reset cases.
module tb_pkt_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start, stop;
   logic [6:0]  cfg_len;
   logic [7:0]  cfg_gap;
   logic [15:0] cfg_num;
   logic [3:0]  cfg_port;
   logic        cfg_port_inc;
   logic [2:0]  cfg_prio;
   logic        cfg_mode;
   logic [15:0] cfg_step;
   logic        busy, done;
   logic [15:0] pkt_cnt;

   always #5 clk = ~clk;

   pkt_gen_if #(.DATA_WIDTH(16)) bus ();

   pkt_gen #(.DATA_WIDTH(16), .PORT_BIT(4), .PRIORITY_BIT(3), .LEN_BIT(7), .CNT_BIT(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start),
      .stop_i         (stop),
      .cfg_len_i      (cfg_len),
      .cfg_gap_i      (cfg_gap),
      .cfg_num_i      (cfg_num),
      .cfg_port_i     (cfg_port),
      .cfg_port_inc_i (cfg_port_inc),
      .cfg_prio_i     (cfg_prio),
      .cfg_mode_i     (cfg_mode),
      .cfg_step_i     (cfg_step),
      .wr             (bus),
      .busy_o         (busy),
      .done_o         (done),
      .pkt_cnt_o      (pkt_cnt)
   );

   typedef struct {
      logic [6:0]  len;
      logic [7:0]  gap;
      logic [15:0] num;
      logic [3:0]  port;
      logic        inc;
      logic [2:0]  prio;
      logic        mode;
      logic [15:0] step;
      int          exp_beats;
      int          exp_gaps;
      logic [15:0] exp_first_hdr;
      logic [15:0] exp_last_hdr;
      logic [15:0] exp_last_pay;
      logic [15:0] exp_cnt;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] cap_data[$];
   bit          cap_sop[$];
   bit          cap_eop[$];
   int          gaps;
   int          dones;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.wr_vld && bus.ready) begin
            cap_data.push_back(bus.wr_data);
            cap_sop.push_back(bus.wr_sop);
            cap_eop.push_back(bus.wr_eop);
            check("sop_eop_same_beat", {31'd0, bus.wr_sop & bus.wr_eop}, 32'd0);
         end
         if (busy && !bus.wr_vld) gaps++;
         if (done) begin
            dones++;
            check("busy_during_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic clear_cap();
      cap_data.delete();
      cap_sop.delete();
      cap_eop.delete();
      gaps  = 0;
      dones = 0;
   endtask

   task automatic set_cfg(input logic [6:0] len, input logic [7:0] gap, input logic [15:0] num,
                          input logic [3:0] port, input logic inc, input logic [2:0] prio,
                          input logic mode, input logic [15:0] step);
      cfg_len = len; cfg_gap = gap; cfg_num = num; cfg_port = port;
      cfg_port_inc = inc; cfg_prio = prio; cfg_mode = mode; cfg_step = step;
   endtask

   task automatic start_run();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      check("done_seen", {31'd0, ok}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic summarize(output int nb, output int ns, output int ne,
                            output logic [15:0] fh, output logic [15:0] lh, output logic [15:0] lp);
      nb = cap_data.size(); ns = 0; ne = 0; fh = 16'hDEAD; lh = 16'hDEAD; lp = 16'hDEAD;
      for (int k = 0; k < nb; k++) begin
         if (cap_sop[k]) begin
            if (ns == 0) fh = cap_data[k];
            ns++;
            lh = cap_data[k];
         end else begin
            lp = cap_data[k];
         end
         if (cap_eop[k]) ne++;
      end
   endtask

   vec_t        vecs[5];
   logic [15:0] seq0[8];
   int          nb, ns, ne, j;
   logic [15:0] fh, lh, lp;
   bit          quiet;

   initial begin
      start = 1'b0; stop = 1'b0; bus.ready = 1'b1;
      set_cfg(7'd0, 8'd0, 16'd0, 4'd0, 1'b0, 3'd0, 1'b0, 16'd0);

      //          len    gap    num     port  inc   prio  mode  step      beats gaps fhdr      lhdr      lpay      cnt
      vecs[0] = '{7'd3,  8'd0, 16'd2,  4'd5,  1'b0, 3'd2, 1'b0, 16'd2,    8,    0,   16'h01A5, 16'h01A5, 16'h000A, 16'd2};
      vecs[1] = '{7'd3,  8'd4, 16'd2,  4'd5,  1'b1, 3'd2, 1'b0, 16'd2,    8,    4,   16'h01A5, 16'h01A6, 16'h000A, 16'd2};
      vecs[2] = '{7'd0,  8'd1, 16'd3,  4'd15, 1'b1, 3'd7, 1'b0, 16'hFFFF, 6,    2,   16'h00FF, 16'h00F1, 16'hFFFE, 16'd3};
      vecs[3] = '{7'd17, 8'd0, 16'd2,  4'd15, 1'b1, 3'd0, 1'b1, 16'd5,    36,   0,   16'h088F, 16'h0880, 16'h0002, 16'd2};
      vecs[4] = '{7'd2,  8'd9, 16'd1,  4'd3,  1'b0, 3'd1, 1'b0, 16'h1234, 3,    0,   16'h0113, 16'h0113, 16'h1234, 16'd1};
      seq0 = '{16'h01A5, 16'h0000, 16'h0002, 16'h0004, 16'h01A5, 16'h0006, 16'h0008, 16'h000A};

      #3;
      check("rst_vld",  {31'd0, bus.wr_vld}, 32'd0);
      check("rst_sop",  {31'd0, bus.wr_sop}, 32'd0);
      check("rst_eop",  {31'd0, bus.wr_eop}, 32'd0);
      check("rst_data", {16'd0, bus.wr_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_cnt",  {16'd0, pkt_cnt}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         clear_cap();
         set_cfg(vecs[i].len, vecs[i].gap, vecs[i].num, vecs[i].port, vecs[i].inc,
                 vecs[i].prio, vecs[i].mode, vecs[i].step);
         start_run();
         wait_done();
         summarize(nb, ns, ne, fh, lh, lp);
         check($sformatf("v%0d_beats", i), nb, vecs[i].exp_beats);
         check($sformatf("v%0d_gaps", i), gaps, vecs[i].exp_gaps);
         check($sformatf("v%0d_sops", i), ns, {16'd0, vecs[i].exp_cnt});
         check($sformatf("v%0d_eops", i), ne, {16'd0, vecs[i].exp_cnt});
         check($sformatf("v%0d_first_hdr", i), {16'd0, fh}, {16'd0, vecs[i].exp_first_hdr});
         check($sformatf("v%0d_last_hdr", i), {16'd0, lh}, {16'd0, vecs[i].exp_last_hdr});
         check($sformatf("v%0d_last_pay", i), {16'd0, lp}, {16'd0, vecs[i].exp_last_pay});
         check($sformatf("v%0d_pkt_cnt", i), {16'd0, pkt_cnt}, {16'd0, vecs[i].exp_cnt});
         check($sformatf("v%0d_done_pulses", i), dones, 1);
         check($sformatf("v%0d_first_is_sop", i), (nb > 0) ? {31'd0, cap_sop[0]} : 32'd0, 32'd1);
         if (i == 0) begin
            for (int k = 0; k < 8 && k < nb; k++)
               check($sformatf("v0_beat%0d", k), {16'd0, cap_data[k]}, {16'd0, seq0[k]});
         end
         if (vecs[i].mode) begin
            j = 0;
            for (int k = 0; k < nb; k++) begin
               if (!cap_sop[k]) begin
                  check($sformatf("walk_pay%0d", j), {16'd0, cap_data[k]}, 32'd1 << (j % 16));
                  j++;
               end
            end
         end
      end

      // ready held low for 3 cycles while payload beat 2 is presented
      clear_cap();
      set_cfg(7'd3, 8'd0, 16'd1, 4'd5, 1'b0, 3'd2, 1'b0, 16'd2);
      start_run();
      @(posedge clk); @(posedge clk); #1 bus.ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_vld",  {31'd0, bus.wr_vld}, 32'd1);
         check("stall_data", {16'd0, bus.wr_data}, 32'h0002);
         check("stall_eop",  {31'd0, bus.wr_eop}, 32'd0);
         @(posedge clk);
      end
      #1 bus.ready = 1'b1;
      wait_done();
      summarize(nb, ns, ne, fh, lh, lp);
      check("stall_beats", nb, 4);
      for (int k = 0; k < 4 && k < nb; k++)
         check($sformatf("stall_beat%0d", k), {16'd0, cap_data[k]}, (k == 0) ? 32'h01A5 : 32'(2 * (k - 1)));

      // unlimited run, start ignored while busy, stop mid-packet
      clear_cap();
      set_cfg(7'd4, 8'd2, 16'd0, 4'd1, 1'b0, 3'd0, 1'b0, 16'd1);
      start_run();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      wait_done();
      summarize(nb, ns, ne, fh, lh, lp);
      check("stop_beats", nb, 5);
      check("stop_sops", ns, 1);
      check("stop_eops", ne, 1);
      check("stop_last_pay", {16'd0, lp}, 32'h0003);
      check("stop_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
      check("stop_last_eop", (nb > 0) ? {31'd0, cap_eop[nb-1]} : 32'd0, 32'd1);

      // stop during the gap: no further header
      clear_cap();
      set_cfg(7'd1, 8'd5, 16'd0, 4'd2, 1'b0, 3'd0, 1'b0, 16'd1);
      start_run();
      quiet = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy && !bus.wr_vld) begin
            quiet = 1'b1;
            break;
         end
      end
      check("gap_reached", {31'd0, quiet}, 32'd1);
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      wait_done();
      summarize(nb, ns, ne, fh, lh, lp);
      check("gapstop_beats", nb, 2);
      check("gapstop_gaps", gaps, 2);
      check("gapstop_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

      // start and stop together in IDLE: the stop is discarded
      clear_cap();
      set_cfg(7'd1, 8'd0, 16'd2, 4'd0, 1'b0, 3'd0, 1'b0, 16'd1);
      @(posedge clk); #1 start = 1'b1; stop = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      wait_done();
      summarize(nb, ns, ne, fh, lh, lp);
      check("startstop_beats", nb, 4);
      check("startstop_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);

      // reset asserted while payload beat 2 is on the bus
      clear_cap();
      set_cfg(7'd3, 8'd0, 16'd0, 4'd5, 1'b0, 3'd2, 1'b0, 16'd2);
      start_run();
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("pre_rst_data", {16'd0, bus.wr_data}, 32'h0002);
      #2 rst_n = 1'b0;
      #1;
      check("arst_vld",  {31'd0, bus.wr_vld}, 32'd0);
      check("arst_sop",  {31'd0, bus.wr_sop}, 32'd0);
      check("arst_eop",  {31'd0, bus.wr_eop}, 32'd0);
      check("arst_data", {16'd0, bus.wr_data}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_cnt",  {16'd0, pkt_cnt}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.wr_vld || busy) quiet = 1'b0;
      end
      check("no_resume_after_rst", {31'd0, quiet}, 32'd1);
      clear_cap();
      set_cfg(7'd1, 8'd0, 16'd1, 4'd9, 1'b0, 3'd4, 1'b0, 16'd1);
      start_run();
      wait_done();
      summarize(nb, ns, ne, fh, lh, lp);
      check("post_rst_beats", nb, 2);
      check("post_rst_hdr", {16'd0, fh}, 32'h00C9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
